// File: rtl/adder_seq_pkg.sv
// Shared types and default sizing for sequencers that wrap multi-cycle
// combinational stages (operand launch, settle, capture).
package adder_seq_pkg;

    // Default operand/sum width of the wrapped adder.
    localparam int DEF_WIDTH = 4;

    // Clock edges between operand launch and result capture. Two edges at a
    // 10-unit clock give 20 units, which covers the adder's 12-unit delay.
    localparam int DEF_SETTLE_CYCLES = 2;

    // Sequencer states:
    //   IDLE   - no transaction held, ready for new operands
    //   SETTLE - operands driven into the adder, waiting for it to settle
    //   HOLD   - result captured and presented downstream
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_e;

endpackage

// File: rtl/adder_op_sequencer_settle_timer.sv
// Load/decrement down-counter used to time the settle window of a
// combinational stage. done is high whenever the count has reached zero.
module settle_timer #(
    parameter int               CNT_W    = 2,
    parameter logic [CNT_W-1:0] LOAD_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             dec,
    output logic             done,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: load wins over decrement; the counter never wraps below zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = LOAD_VAL;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Count register, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == '0);
    assign cnt  = cnt_q;

endmodule

// File: rtl/adder_op_sequencer.sv
// Wraps the combinational {co, sum} = a + b + ci adder. Operands are taken on a
// valid/ready input, registered onto add_*, held untouched for SETTLE_CYCLES
// clock edges so the adder's inertial delay never swallows an output event,
// then {add_co, add_sum} is captured and offered on a valid/ready output.
//
// Handshake rule (both ports): a transfer happens on a rising clk edge where
// valid and ready are both high. A source keeps valid and its payload steady
// until that transfer; valid never drops without a transfer. in_ready may
// depend combinationally on out_ready (accept-while-draining in HOLD); no
// other input reaches an output without passing through a register.
module adder_op_sequencer
    import adder_seq_pkg::*;
#(
    parameter int WIDTH         = DEF_WIDTH,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int CNT_W         = $clog2(SETTLE_CYCLES + 1)
) (
    input  logic             clk,
    input  logic             rst,
    // operand transaction in
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_ci,
    // registered operands to the adder and its raw result
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_ci,
    input  logic             add_co,
    input  logic [WIDTH-1:0] add_sum,
    // captured result out
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_co,
    output logic [WIDTH-1:0] out_sum,
    // current state, for observation only
    output state_e           dbg_state
);

    // Settle count loaded at launch. SETTLE_CYCLES must be at least 1; the
    // capture then lands exactly SETTLE_CYCLES edges after the launch edge.
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   add_a_q, add_a_d;
    logic [WIDTH-1:0]   add_b_q, add_b_d;
    logic               add_ci_q, add_ci_d;
    logic               out_valid_q, out_valid_d;
    logic               out_co_q, out_co_d;
    logic [WIDTH-1:0]   out_sum_q, out_sum_d;

    logic               accept;
    logic               timer_load;
    logic               timer_dec;
    logic               timer_done;
    logic [CNT_W-1:0]   timer_cnt;

    // Ready when empty, or when the held result is being drained this edge.
    assign in_ready = (state_q == IDLE) || ((state_q == HOLD) && out_ready);
    assign accept   = in_valid && in_ready;

    settle_timer #(
        .CNT_W    (CNT_W),
        .LOAD_VAL (SETTLE_LOAD)
    ) u_settle_timer (
        .clk  (clk),
        .rst  (rst),
        .load (timer_load),
        .dec  (timer_dec),
        .done (timer_done),
        .cnt  (timer_cnt)
    );

    // Next-state and datapath enables. add_* are only ever loaded on an
    // accept, which is what keeps the adder inputs quiet during SETTLE.
    always_comb begin
        state_d     = state_q;
        add_a_d     = add_a_q;
        add_b_d     = add_b_q;
        add_ci_d    = add_ci_q;
        out_valid_d = out_valid_q;
        out_co_d    = out_co_q;
        out_sum_d   = out_sum_q;
        timer_load  = 1'b0;
        timer_dec   = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    add_a_d    = in_a;
                    add_b_d    = in_b;
                    add_ci_d   = in_ci;
                    timer_load = 1'b1;
                    state_d    = SETTLE;
                end
            end

            SETTLE: begin
                if (timer_done) begin
                    out_co_d    = add_co;
                    out_sum_d   = add_sum;
                    out_valid_d = 1'b1;
                    state_d     = HOLD;
                end else begin
                    timer_dec = 1'b1;
                end
            end

            HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (accept) begin
                        add_a_d    = in_a;
                        add_b_d    = in_b;
                        add_ci_d   = in_ci;
                        timer_load = 1'b1;
                        state_d    = SETTLE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and data registers; reset discards any in-flight transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            add_a_q     <= '0;
            add_b_q     <= '0;
            add_ci_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_co_q    <= 1'b0;
            out_sum_q   <= '0;
        end else begin
            state_q     <= state_d;
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            add_ci_q    <= add_ci_d;
            out_valid_q <= out_valid_d;
            out_co_q    <= out_co_d;
            out_sum_q   <= out_sum_d;
        end
    end

    assign add_a     = add_a_q;
    assign add_b     = add_b_q;
    assign add_ci    = add_ci_q;
    assign out_valid = out_valid_q;
    assign out_co    = out_co_q;
    assign out_sum   = out_sum_q;
    assign dbg_state = state_q;

    // Upstream must keep a waiting transaction's operands steady.
    a_in_stable : assert property (@(posedge clk) disable iff (rst)
        (in_valid && !in_ready) |=> (!in_valid || $stable({in_a, in_b, in_ci})));

    // A presented result stays put until it is taken.
    a_out_hold : assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready) |=> (out_valid && $stable({out_co, out_sum})));

    // The settle counter is only non-zero while settling.
    a_cnt_idle : assert property (@(posedge clk) disable iff (rst)
        (state_q != SETTLE) |-> (timer_cnt == '0));

endmodule

// File: tb/tb_adder_op_sequencer.sv
// Bench for adder_op_sequencer. Three instances share clk/rst, each wired to
// its own behavioural adder with a 12-unit delay:
//   0: SETTLE_CYCLES = 2 (default), 1: SETTLE_CYCLES = 1, 2: SETTLE_CYCLES = 3.
// Inputs are driven on the falling edge or 1 unit after the rising edge;
// outputs are sampled on the falling edge.
module tb_adder_op_sequencer;
    import adder_seq_pkg::*;

    localparam int W = 4;
    localparam int N = 3;
    localparam int LIMIT = 200;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic         in_valid_v  [N];
    logic         in_ready_v  [N];
    logic [W-1:0] in_a_v      [N];
    logic [W-1:0] in_b_v      [N];
    logic         in_ci_v     [N];
    logic [W-1:0] add_a_v     [N];
    logic [W-1:0] add_b_v     [N];
    logic         add_ci_v    [N];
    logic         add_co_v    [N];
    logic [W-1:0] add_sum_v   [N];
    logic         out_valid_v [N];
    logic         out_ready_v [N];
    logic         out_co_v    [N];
    logic [W-1:0] out_sum_v   [N];
    state_e       dbg_v       [N];
    int           bad_chg_v   [N];

    int n_assert = 0;
    int n_fail   = 0;

    // Expected results (model) and the accept time of each transaction.
    logic [W:0] exp_q[$];
    time        acc_q[$];
    logic [W:0] prev_fresh = '0;

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int SC = (g == 1) ? 1 : ((g == 2) ? 3 : 2);

        adder_op_sequencer #(
            .WIDTH         (W),
            .SETTLE_CYCLES (SC)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid_v[g]),
            .in_ready  (in_ready_v[g]),
            .in_a      (in_a_v[g]),
            .in_b      (in_b_v[g]),
            .in_ci     (in_ci_v[g]),
            .add_a     (add_a_v[g]),
            .add_b     (add_b_v[g]),
            .add_ci    (add_ci_v[g]),
            .add_co    (add_co_v[g]),
            .add_sum   (add_sum_v[g]),
            .out_valid (out_valid_v[g]),
            .out_ready (out_ready_v[g]),
            .out_co    (out_co_v[g]),
            .out_sum   (out_sum_v[g]),
            .dbg_state (dbg_v[g])
        );

        // Behavioural adder: result appears 12 units after an operand change.
        logic [W:0] res = '0;
        always @(add_a_v[g] or add_b_v[g] or add_ci_v[g])
            res <= #12 {1'b0, add_a_v[g]} + {1'b0, add_b_v[g]} + (W+1)'(add_ci_v[g]);
        assign add_co_v[g]  = res[W];
        assign add_sum_v[g] = res[W-1:0];

        // Operand stability watch: add_* may only move on an accept or reset edge.
        int bad = 0;
        logic acc_s, rst_s;
        logic [2*W:0] snap;
        always begin
            @(posedge clk);
            acc_s = in_valid_v[g] && in_ready_v[g];
            rst_s = rst;
            snap  = {add_a_v[g], add_b_v[g], add_ci_v[g]};
            #1;
            if (({add_a_v[g], add_b_v[g], add_ci_v[g]} !== snap) &&
                (acc_s !== 1'b1) && (rst_s !== 1'b1))
                bad++;
        end
        assign bad_chg_v[g] = bad;
    end

    function automatic int sc_of(input int k);
        return (k == 1) ? 1 : ((k == 2) ? 3 : 2);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Offer one transaction and hold it until accepted; record the model result.
    task automatic send(input int k, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic ci);
        int g = 0;
        int s;
        @(negedge clk);
        in_a_v[k]     = a;
        in_b_v[k]     = b;
        in_ci_v[k]    = ci;
        in_valid_v[k] = 1'b1;
        while ((in_ready_v[k] !== 1'b1) && (g < LIMIT)) begin
            @(negedge clk);
            g++;
        end
        chk("tx_wait", 32'(g < LIMIT), 32'd1);
        @(posedge clk);
        s = int'(a) + int'(b) + int'(ci);
        exp_q.push_back((W+1)'(s));
        acc_q.push_back($time);
        #1 in_valid_v[k] = 1'b0;
    endtask

    // Wait for a result, check it against the model and the launch-to-capture
    // latency, then optionally wait for it to be taken. In stale mode the
    // expected capture is the previous transaction's sum (adder not settled).
    task automatic recv(input int k, input bit consume, input bit stale,
                        output logic [W:0] got, output time edge_t);
        int g = 0;
        logic [W:0] fresh;
        time acc_t;
        @(negedge clk);
        while ((out_valid_v[k] !== 1'b1) && (g < LIMIT)) begin
            @(negedge clk);
            g++;
        end
        chk("rx_wait", 32'(g < LIMIT), 32'd1);
        edge_t = $time - 5;
        got    = {out_co_v[k], out_sum_v[k]};
        chk("rx_queue", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
            fresh = exp_q.pop_front();
            acc_t = acc_q.pop_front();
        end else begin
            fresh = '0;
            acc_t = 0;
        end
        if (stale) begin
            chk("stale_capture", 32'(got), 32'(prev_fresh));
            chk("stale_differs", 32'(got !== fresh), 32'd1);
            prev_fresh = fresh;
        end else begin
            chk("result", 32'(got), 32'(fresh));
        end
        chk("latency", 32'((edge_t - acc_t) / 10), 32'(sc_of(k)));
        if (consume) begin
            g = 0;
            while ((out_ready_v[k] !== 1'b1) && (g < LIMIT)) begin
                @(negedge clk);
                g++;
            end
            chk("rx_drain", 32'(g < LIMIT), 32'd1);
            @(posedge clk);
            #1;
        end
    endtask

    // Random operands with random downstream backpressure.
    task automatic run_random(input int k, input int n);
        bit done = 1'b0;
        fork
            begin
                for (int i = 0; i < n; i++)
                    send(k, W'($urandom_range(0, 15)), W'($urandom_range(0, 15)),
                         1'($urandom_range(0, 1)));
            end
            begin
                logic [W:0] got;
                time et;
                for (int i = 0; i < n; i++) recv(k, 1'b1, 1'b0, got, et);
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1 out_ready_v[k] = 1'($urandom_range(0, 1));
                end
                out_ready_v[k] = 1'b1;
            end
        join
    endtask

    initial begin
        logic [W:0] got;
        time        et;
        time        prev_et;
        bit         ok;

        for (int k = 0; k < N; k++) begin
            in_valid_v[k]  = 1'b0;
            in_a_v[k]      = '0;
            in_b_v[k]      = '0;
            in_ci_v[k]     = 1'b0;
            out_ready_v[k] = 1'b1;
        end

        // Reset held two edges with a transaction offered: it must be ignored.
        in_valid_v[0] = 1'b1;
        in_a_v[0]     = 4'hF;
        in_b_v[0]     = 4'hF;
        in_ci_v[0]    = 1'b1;
        rst           = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_out_valid_in_reset", 32'(out_valid_v[0]), 32'd0);
        rst           = 1'b0;
        in_valid_v[0] = 1'b0;
        for (int k = 0; k < N; k++) begin
            chk("rst_in_ready", 32'(in_ready_v[k]), 32'd1);
            chk("rst_add", 32'({add_a_v[k], add_b_v[k], add_ci_v[k]}), 32'd0);
            chk("rst_out", 32'({out_valid_v[k], out_co_v[k], out_sum_v[k]}), 32'd0);
            chk("rst_state", 32'(dbg_v[k]), 32'(IDLE));
        end

        // Single transaction 9 + 8 + 1.
        send(0, 4'h9, 4'h8, 1'b1);
        recv(0, 1'b1, 1'b0, got, et);

        // Backpressure: result and operands frozen while out_ready is low.
        out_ready_v[0] = 1'b0;
        send(0, 4'hA, 4'h7, 1'b0);
        recv(0, 1'b0, 1'b0, got, et);
        ok = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if ({out_valid_v[0], out_co_v[0], out_sum_v[0]} !== {1'b1, 5'h11}) ok = 1'b0;
            if ({add_a_v[0], add_b_v[0], add_ci_v[0]} !== {4'hA, 4'h7, 1'b0}) ok = 1'b0;
            if (in_ready_v[0] !== 1'b0) ok = 1'b0;
        end
        chk("bp_hold", 32'(ok), 32'd1);
        out_ready_v[0] = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", 32'(out_valid_v[0]), 32'd0);
        chk("bp_release_state", 32'(dbg_v[0]), 32'(IDLE));
        chk("bp_release_ready", 32'(in_ready_v[0]), 32'd1);

        // Back-to-back streaming: one result every SETTLE_CYCLES+1 cycles.
        fork
            begin
                send(0, 4'h3, 4'h4, 1'b0);
                send(0, 4'hF, 4'hF, 1'b1);
                send(0, 4'h0, 4'h0, 1'b0);
            end
            begin
                prev_et = 0;
                for (int i = 0; i < 3; i++) begin
                    recv(0, 1'b1, 1'b0, got, et);
                    if (i > 0) chk("stream_spacing", 32'((et - prev_et) / 10), 32'(sc_of(0) + 1));
                    prev_et = et;
                end
            end
        join

        // Reset one edge after an accept: the transaction vanishes.
        send(0, 4'h5, 4'h5, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        acc_q.delete();
        ok = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (out_valid_v[0] !== 1'b0) ok = 1'b0;
        end
        chk("rst_mid_no_valid", 32'(ok), 32'd1);
        chk("rst_mid_add", 32'({add_a_v[0], add_b_v[0], add_ci_v[0]}), 32'd0);
        send(0, 4'h1, 4'h1, 1'b0);
        recv(0, 1'b1, 1'b0, got, et);

        run_random(0, 12);

        // SETTLE_CYCLES = 1 is too short for the 12-unit adder: stale captures.
        prev_fresh = '0;
        send(1, 4'h3, 4'h4, 1'b0);
        recv(1, 1'b1, 1'b1, got, et);
        send(1, 4'hF, 4'hF, 1'b1);
        recv(1, 1'b1, 1'b1, got, et);
        send(1, 4'h0, 4'h0, 1'b0);
        recv(1, 1'b1, 1'b1, got, et);

        // SETTLE_CYCLES = 3: correct results with latency 3.
        send(2, 4'h9, 4'h8, 1'b1);
        recv(2, 1'b1, 1'b0, got, et);
        run_random(2, 8);

        for (int k = 0; k < N; k++)
            chk("operand_stability", 32'(bad_chg_v[k]), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/adder_op_sequencer.md
Name: adder_op_sequencer

Overview:
- Upstream/downstream wrapper for the combinational `{co, sum} = a + b + ci` adder stage. That adder has a 12-time-unit inertial delay on its continuous assign.
- Accepts operand transactions on a valid/ready input and drives registered operands into the adder.
- Holds those operands stable for a programmable settle window, then captures `{co, sum}`.
- Presents the captured result on a valid/ready output.
- Guarantees the adder never sees operand changes inside its inertial window, so no output events are swallowed.

Parameters:
- WIDTH, 4, operand and sum width.
- SETTLE_CYCLES, 2, clock edges between operand launch and capture. Must be at least 1. The default covers the 12-unit adder delay at a 10-unit clock period.
- CNT_W, $clog2(SETTLE_CYCLES+1), derived settle-counter width. Not overridden.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  operand transaction valid
- in_ready  output  1  sequencer can accept operands
- in_a  input  WIDTH  operand a
- in_b  input  WIDTH  operand b
- in_ci  input  1  carry-in
- add_a  output  WIDTH  registered operand a to the adder
- add_b  output  WIDTH  registered operand b to the adder
- add_ci  output  1  registered carry-in to the adder
- add_co  input  1  adder carry-out
- add_sum  input  WIDTH  adder sum
- out_valid  output  1  captured result valid
- out_ready  input  1  downstream accepts the result
- out_co  output  1  captured carry-out
- out_sum  output  WIDTH  captured sum

Behaviour:
- Reset: synchronous, active-high, sampled at the clk rising edge. It overrides every other event, including any accept or capture in the same cycle. After reset:
  - state = IDLE, cnt = 0, out_valid = 0
  - add_a = add_b = 0, add_ci = 0
  - out_co = 0, out_sum = 0
- States are IDLE, SETTLE and HOLD. An accept is `in_valid && in_ready` at a clk edge.
- in_ready = (state == IDLE) || (state == HOLD && out_ready). The HOLD term is combinational from out_ready. No other combinational in-to-out paths exist.
- IDLE:
  - On accept: add_* <= in_*, cnt <= SETTLE_CYCLES-1, go to SETTLE.
  - Otherwise stay in IDLE with add_* unchanged.
- SETTLE:
  - add_* are frozen.
  - If cnt != 0: cnt <= cnt-1.
  - If cnt == 0: out_co <= add_co, out_sum <= add_sum, out_valid <= 1, go to HOLD.
- HOLD:
  - out_* and add_* are frozen while out_ready = 0.
  - out_ready = 1 and in_valid = 1: the result is consumed and the new operands are accepted in the same edge. add_* <= in_*, out_valid <= 0, cnt <= SETTLE_CYCLES-1, go to SETTLE.
  - out_ready = 1 and in_valid = 0: out_valid <= 0, go to IDLE.
- Latency: accept at edge N updates add_* at edge N. Capture happens at edge N+SETTLE_CYCLES, and out_valid is high from that edge onward. Throughput is one result per SETTLE_CYCLES+1 cycles under continuous streaming.
- Operand stability: add_* change only at an accept edge or at reset. This is a hard invariant.
- Width: out_sum is WIDTH bits and out_co is the (WIDTH+1)th bit. The full range up to 2*(2^WIDTH-1)+1 is represented exactly, with no truncation.
- out_valid, once high, stays high until the out_ready handshake; standard AXI-style stability applies.
- Upstream obligation: in_a, in_b and in_ci must be stable while in_valid is high and not accepted. This is assertion-checked, not enforced.
- Reset during SETTLE or HOLD: the in-flight transaction is discarded and no out_valid pulse is produced.

Decomposition:
- Shared package adder_seq_pkg:
  - state enum (IDLE, SETTLE, HOLD)
  - default WIDTH and SETTLE_CYCLES constants
- One sub-module, settle_timer:
  - a load/decrement down-counter with a done flag at cnt == 0
  - reused by later multi-cycle combinational-stage sequencers
- State machine and data registers stay in adder_op_sequencer.

Test Plan:
- Reset: assert rst for 2 cycles with in_valid = 1 → out_valid = 0, in_ready = 1 after release, add_* = 0, out_* = 0.
- Single transaction, behavioural adder #12 and 10-unit clock, a = 4'h9, b = 4'h8, ci = 1 accepted at edge N → out_valid rises at edge N+2 with out_co = 1, out_sum = 4'h2.
- Backpressure: hold out_ready = 0 for 5 cycles after out_valid → out_*, out_valid and add_* stay constant and in_ready = 0. Raise out_ready with in_valid = 0 → IDLE on the next edge.
- Back-to-back streaming: out_ready tied to 1, transactions (3,4,0), (F,F,1), (0,0,0) → results {0,7}, {1,F}, {0,0}, one every 3 cycles. add_* never change during SETTLE (checked against the adder's output-event count).
- Reset mid-SETTLE: accept a = 4'h5, b = 4'h5, then assert rst one edge later → no out_valid ever; the next transaction a = 1, b = 1, ci = 0 returns out_sum = 4'h2, out_co = 0.
- Parameter check: SETTLE_CYCLES = 1 with the #12 adder and 10-unit clock → the capture is stale, and the bench flags a mismatch (documents the minimum setting). SETTLE_CYCLES = 3 → correct results with latency 3.
